// File: rtl/efpga_macc_stream.sv
// efpga_macc_stream: parametrised, pipelined multiply-accumulate engine.
//
// Pipeline: optional S0 (input registers) -> optional S1 (product register)
// -> S2 (accumulator, drives y). Each beat carries an opcode selecting
// accumulate, restart, add-C or load-C. A single advance signal stalls every
// stage at once when the output is held by downstream backpressure.
//
// Build option: define EFPGA_MACC_SAT_EN to clamp ACC/ADDC results on
// overflow instead of wrapping modulo 2^ACC_WIDTH.
module efpga_macc_stream #(
  parameter int unsigned A_WIDTH   = 18,
  parameter int unsigned B_WIDTH   = 18,
  parameter int unsigned ACC_WIDTH = 40,
  parameter bit          SIGNED    = 1'b1,
  parameter bit          IN_REG    = 1'b1,
  parameter bit          MULT_REG  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [A_WIDTH-1:0]   a,
  input  logic [B_WIDTH-1:0]   b,
  input  logic [ACC_WIDTH-1:0] c,
  input  logic [1:0]           op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] y,
  output logic                 ovf
);

  localparam int unsigned P_WIDTH = A_WIDTH + B_WIDTH;

  typedef enum logic [1:0] {
    OP_ACC   = 2'b00,
    OP_CLR   = 2'b01,
    OP_ADDC  = 2'b10,
    OP_LOADC = 2'b11
  } op_e;

  // The accumulator must hold a full-precision product.
  if (ACC_WIDTH < P_WIDTH) begin : g_width_check
    $error("efpga_macc_stream: ACC_WIDTH must be >= A_WIDTH+B_WIDTH");
  end

  logic                 advance;

  logic                 s0_valid;
  logic [A_WIDTH-1:0]   s0_a;
  logic [B_WIDTH-1:0]   s0_b;
  logic [ACC_WIDTH-1:0] s0_c;
  op_e                  s0_op;

  logic [P_WIDTH-1:0]   a_ext;
  logic [P_WIDTH-1:0]   b_ext;
  logic [P_WIDTH-1:0]   prod;
  logic [ACC_WIDTH-1:0] prod_ext;

  logic                 s1_valid;
  logic [ACC_WIDTH-1:0] s1_p;
  logic [ACC_WIDTH-1:0] s1_c;
  op_e                  s1_op;

  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] acc_next;
  logic [ACC_WIDTH-1:0] addend;
  logic [ACC_WIDTH:0]   sum;
  logic                 ovf_hit;
  logic                 ovf_next;

  // Whole pipeline moves together; it only stops when a result is being held.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // ---------------------------------------------------------------- S0
  if (IN_REG) begin : g_in_reg
    // Capture the incoming beat (or bubble) whenever the pipeline advances.
    always_ff @(posedge clk or posedge rst) begin
      // NOTE: datapath registers are reset along with the valids so a
      // restart never exposes stale operands; there is no memory array here.
      if (rst) begin
        s0_valid <= 1'b0;
        s0_a     <= '0;
        s0_b     <= '0;
        s0_c     <= '0;
        s0_op    <= OP_ACC;
      end else if (advance) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // stage samples the previous stage's pre-edge value.
        s0_valid <= in_valid;
        s0_a     <= a;
        s0_b     <= b;
        s0_c     <= c;
        s0_op    <= op_e'(op);
      end
    end
  end else begin : g_in_comb
    assign s0_valid = in_valid;
    assign s0_a     = a;
    assign s0_b     = b;
    assign s0_c     = c;
    assign s0_op    = op_e'(op);
  end

  // Operands extended to product width so one multiplier serves both modes.
  assign a_ext = {{B_WIDTH{SIGNED & s0_a[A_WIDTH-1]}}, s0_a};
  assign b_ext = {{A_WIDTH{SIGNED & s0_b[B_WIDTH-1]}}, s0_b};
  assign prod  = a_ext * b_ext;

  // Widen the product to accumulator width (sign- or zero-extension).
  always_comb begin
    // NOTE: every bit is given a value before the partial overwrite below,
    // so no path through this block can infer a latch.
    prod_ext              = {ACC_WIDTH{SIGNED & prod[P_WIDTH-1]}};
    prod_ext[P_WIDTH-1:0] = prod;
  end

  // ---------------------------------------------------------------- S1
  if (MULT_REG) begin : g_mult_reg
    // Register the widened product together with the beat's opcode and C.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1_valid <= 1'b0;
        s1_p     <= '0;
        s1_c     <= '0;
        s1_op    <= OP_ACC;
      end else if (advance) begin
        s1_valid <= s0_valid;
        s1_p     <= prod_ext;
        s1_c     <= s0_c;
        s1_op    <= s0_op;
      end
    end
  end else begin : g_mult_comb
    assign s1_valid = s0_valid;
    assign s1_p     = prod_ext;
    assign s1_c     = s0_c;
    assign s1_op    = s0_op;
  end

  // ---------------------------------------------------------------- S2
  // Next accumulator value and overflow detection for the beat in S1.
  always_comb begin
    addend   = (s1_op == OP_ACC) ? acc : s1_c;
    sum      = {1'b0, addend} + {1'b0, s1_p};
    if (SIGNED)
      ovf_hit = (addend[ACC_WIDTH-1] == s1_p[ACC_WIDTH-1]) &&
                (sum[ACC_WIDTH-1] != addend[ACC_WIDTH-1]);
    else
      ovf_hit = sum[ACC_WIDTH];
    acc_next = sum[ACC_WIDTH-1:0];
    ovf_next = ovf || ovf_hit;
    case (s1_op)
      OP_CLR: begin
        acc_next = s1_p;
        ovf_next = 1'b0;
      end
      OP_LOADC: begin
        acc_next = s1_c;
        ovf_next = 1'b0;
      end
      default: begin
`ifdef EFPGA_MACC_SAT_EN
        // Clamp toward the side both addends were heading.
        if (ovf_hit) begin
          if (!SIGNED)
            acc_next = '1;
          else if (addend[ACC_WIDTH-1])
            acc_next = {1'b1, {(ACC_WIDTH-1){1'b0}}};
          else
            acc_next = {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end
`endif
      end
    endcase
  end

  // Accumulator, sticky overflow and output valid; bubbles leave acc/ovf.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else if (advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        acc <= acc_next;
        ovf <= ovf_next;
      end
    end
  end

  assign y = acc;

endmodule
